// File: rtl/lcd_req_arbiter_if.sv
// Requester-side and write-engine-side signals of the LCD request arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface lcd_req_arbiter_if;
  logic       init_done;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic       tx_start;
  logic       tx_rs;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       owner;

  modport slave (
    input  init_done, req0, rs0, data0, req1, rs1, data1, tx_done,
    output ack0, ack1, tx_start, tx_rs, tx_data, busy, owner
  );

  modport master (
    output init_done, req0, rs0, data0, req1, rs1, data1, tx_done,
    input  ack0, ack1, tx_start, tx_rs, tx_data, busy, owner
  );
endinterface

// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter sharing the HD44780 byte-write engine between two requesters,
// inserting the controller's post-write settle time (long after clear/home).
module lcd_req_arbiter #(
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 82000,
  parameter int CNT_W      = 21
) (
  input logic               clk,
  input logic               rst_n,
  lcd_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_TX,
    SETTLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rr_ptr;
  logic             winner;
  logic             long_cmd;

  // Tie goes to the requester that was not granted last; a sole requester always wins.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) winner = ~rr_ptr;
  end

  // Clear display (0x01) and return home (0x02) need the long settle time.
  assign long_cmd = !bus.tx_rs && (bus.tx_data == 8'h01 || bus.tx_data == 8'h02);

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // branch of the case sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= 1'b1;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_rs    <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.busy     <= 1'b0;
      bus.owner    <= 1'b0;
    end else begin
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.init_done && (bus.req0 || bus.req1)) begin
            bus.owner    <= winner;
            rr_ptr       <= winner;
            bus.tx_rs    <= winner ? bus.rs1 : bus.rs0;
            bus.tx_data  <= winner ? bus.data1 : bus.data0;
            bus.ack0     <= ~winner;
            bus.ack1     <= winner;
            bus.tx_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_TX;
        WAIT_TX: begin
          if (bus.tx_done) begin
            cnt   <= long_cmd ? CNT_W'(LONG_WAIT - 1) : CNT_W'(SHORT_WAIT - 1);
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Directed testbench for lcd_req_arbiter: reset, init gating, single grant timing,
// round-robin alternation, long/short settle and reset during settle.
module tb_lcd_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_req_arbiter_if bus ();

  lcd_req_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Poll for the ISSUE cycle and check everything presented in it.
  task automatic grant(input string tag, input logic exp_owner, input logic exp_rs,
                       input logic [7:0] exp_data);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tx_start && n < 16);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_ack0"},     32'(bus.ack0),     32'(!exp_owner));
    check({tag, "_ack1"},     32'(bus.ack1),     32'(exp_owner));
    check({tag, "_owner"},    32'(bus.owner),    32'(exp_owner));
    check({tag, "_tx_rs"},    32'(bus.tx_rs),    32'(exp_rs));
    check({tag, "_tx_data"},  32'(bus.tx_data),  32'(exp_data));
    check({tag, "_busy"},     32'(bus.busy),     32'd1);
  endtask

  // Called in the ISSUE cycle: answer with tx_done lat cycles after tx_start,
  // then verify busy drops exactly wait_cyc cycles after tx_done.
  task automatic finish(input string tag, input int lat, input int wait_cyc,
                        input logic exp_rs, input logic [7:0] exp_data);
    tick();
    check({tag, "_pulses_clear"}, 32'({bus.ack0, bus.ack1, bus.tx_start}), 32'd0);
    repeat (lat - 2) tick();
    check({tag, "_hold"}, 32'({bus.tx_rs, bus.tx_data}), 32'({exp_rs, exp_data}));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    repeat (wait_cyc - 1) tick();
    check({tag, "_busy_last_settle"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.init_done = 1'b0;
    bus.req0 = 1'b1;  bus.rs0 = 1'b1;  bus.data0 = 8'h41;
    bus.req1 = 1'b1;  bus.rs1 = 1'b1;  bus.data1 = 8'h42;
    bus.tx_done = 1'b0;

    // Reset with both requests high.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ack0",     32'(bus.ack0),     32'd0);
    check("rst_ack1",     32'(bus.ack1),     32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'h00);
    check("rst_tx_rs",    32'(bus.tx_rs),    32'd0);
    check("rst_owner",    32'(bus.owner),    32'd0);

    // No grant while init is incomplete; a stray tx_done in IDLE is ignored.
    rst_n = 1'b1;
    bus.req1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bus.tx_done = (i == 100);
      tick();
      check("noinit_idle", 32'({bus.ack0, bus.tx_start, bus.busy}), 32'd0);
    end
    bus.tx_done = 1'b0;

    // Single data write from requester 0, short settle.
    bus.init_done = 1'b1;
    grant("single", 1'b0, 1'b1, 8'h41);
    bus.req0 = 1'b0;
    finish("single", 30, 2000, 1'b1, 8'h41);

    // Requester 1 alone, then reset during its settle.
    bus.req1 = 1'b1;
    grant("pre_rst", 1'b1, 1'b1, 8'h42);
    repeat (4) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    repeat (10) tick();
    check("pre_rst_settling", 32'(bus.busy), 32'd1);
    bus.req0 = 1'b1;  bus.rs0 = 1'b0;  bus.data0 = 8'h01;
    bus.req1 = 1'b1;  bus.rs1 = 1'b1;  bus.data1 = 8'h55;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy",     32'(bus.busy),     32'd0);
    check("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_tx_data",  32'(bus.tx_data),  32'h00);

    // Both held: 0 first (clear display, long settle), then 1, then 0 again.
    grant("rr0_clear", 1'b0, 1'b0, 8'h01);
    bus.data0 = 8'h03;
    finish("rr0_clear", 5, 82000, 1'b0, 8'h01);
    grant("rr1", 1'b1, 1'b1, 8'h55);
    finish("rr1", 5, 2000, 1'b1, 8'h55);
    grant("rr0_cmd03", 1'b0, 1'b0, 8'h03);

    // init_done falls mid-transaction: it completes, then no more grants.
    bus.init_done = 1'b0;
    bus.req0 = 1'b0;
    finish("rr0_cmd03", 5, 2000, 1'b0, 8'h03);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("init_low_idle", 32'({bus.ack1, bus.tx_start, bus.busy}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
